fetch_unit: RTL and testbench

Instruction fetch and program-counter stage for the MIPS processor, directly upstream of the main decoder. Holds the PC, fetches each instruction over a request/acknowledge handshake to instruction memory, and presents it to decode/execute. When execute signals commit, it selects the next PC from the decoder's `jump`, `branch` and `branch_equality` controls and the ALU `zero` flag.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_next_pc_sel.sv | 46 ++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction fetch / program-counter stage.
//   fetch_state_t : fetch sequencer states (IDLE, FETCH, EXEC)
//   XLEN          : datapath width
//   OP_J          : opcode of the J instruction, handy when building test programs
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_J = 6'b000010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if
// Request/acknowledge bus between the fetch stage and instruction memory.
//   imem_req   : fetch request, held until acknowledged (master -> slave)
//   imem_addr  : word-aligned fetch address (master -> slave)
//   imem_ack   : imem_rdata is valid this cycle (slave -> master)
//   imem_rdata : instruction word (slave -> master)
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_next_pc_sel.sv
// next_pc_sel
// Combinational next-PC selection for the fetch stage.
//   pc_plus4        : address of the sequentially following instruction
//   instr_index     : 26-bit jump index field of the current instruction
//   imm_ext         : sign-extended 16-bit immediate (branch word offset)
//   jump            : unconditional jump, highest priority
//   branch          : conditional branch
//   branch_equality : 1 = BEQ (taken on zero), 0 = BNE (taken on not zero)
//   zero            : ALU zero flag
//   next_pc         : selected next PC (alignment is applied by the caller)
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [25:0]     instr_index,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            jump,
  input  logic            branch,
  input  logic            branch_equality,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc
);

  logic            taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;

  // XNOR: BEQ wants zero=1, BNE wants zero=0
  assign taken = branch & ~(zero ^ branch_equality);

  // Word offset scaled to bytes; the top two bits of the offset fall off
  assign branch_target = pc_plus4 + (imm_ext << 2);

  // Jumps stay inside the current 256 MB region of pc_plus4
  assign jump_target = {pc_plus4[XLEN-1:XLEN-4], instr_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch and program-counter stage feeding the main decoder.
// Fetches one instruction at a time over fetch_if, holds it while execute
// works on it, and on commit loads the next PC chosen by next_pc_sel.
//   RESET_PC        : PC after reset (word aligned)
//   INSTRET_RESET   : retired-instruction counter value after reset
//   clk, reset_n    : clock, synchronous active-low reset
//   mem             : instruction memory bus (master side)
//   instr           : instruction register, instr[31:26] is the opcode
//   instr_valid     : instr may be executed
//   pc, pc_plus4    : current PC and PC + 4
//   exec_done       : execute commits the current instruction
//   branch, branch_equality, jump, zero, imm_ext : next-PC controls
//   instret         : retired-instruction counter
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0000,
  parameter logic [XLEN-1:0] INSTRET_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  fetch_if.master         mem,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            exec_done,
  input  logic            branch,
  input  logic            branch_equality,
  input  logic            jump,
  input  logic            zero,
  input  logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] instret
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_t    state;
  fetch_state_t    next_state;
  logic [XLEN-1:0] next_pc;
  logic            fetch_ack;
  logic            retire;

  // Acks are only meaningful while a request is outstanding
  assign fetch_ack = (state == FETCH) && mem.imem_ack;
  assign retire    = (state == EXEC) && exec_done;

  // Bus outputs decode registered state only, so memory sees no input-to-output path
  assign mem.imem_req  = (state == FETCH);
  assign mem.imem_addr = pc;
  assign instr_valid   = (state == EXEC);
  assign pc_plus4      = pc + 32'd4;

  next_pc_sel u_next_pc_sel (
    .pc_plus4        (pc_plus4),
    .instr_index     (instr[25:0]),
    .imm_ext         (imm_ext),
    .jump            (jump),
    .branch          (branch),
    .branch_equality (branch_equality),
    .zero            (zero),
    .next_pc         (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = FETCH;
      FETCH:   if (fetch_ack) next_state = EXEC;
      EXEC:    if (retire) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr <= '0;
    end else if (fetch_ack) begin
      instr <= mem.imem_rdata;
    end
  end

  // Low address bits are cleared on every load so the PC stays word aligned
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_PC & ALIGN_MASK;
    end else if (retire) begin
      pc <= next_pc & ALIGN_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instret <= INSTRET_RESET;
    end else if (retire) begin
      instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Scoreboard bench for fetch_unit. The driver walks a directed program and
// queues the expected fetch address / counter and latched instruction for each
// step; a monitor pops and compares whenever a new request or a newly valid
// instruction appears. A second instance starting its counter at all ones
// retires freely to show the counter wrap.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] count;
    string       name;
  } fetch_exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr, pc, pc_plus4, instret, imm_ext;
  logic        instr_valid, exec_done, branch, branch_equality, jump, zero;

  logic [31:0] instr_b, pc_b, pc_plus4_b, instret_b;
  logic        instr_valid_b;
  logic        ctl_off = 1'b0;
  logic [31:0] imm_off = 32'h0;

  fetch_exp_t  fetch_q[$];
  logic [31:0] instr_q[$];
  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_instret = 32'h0;

  always #5 clk = ~clk;

  fetch_if mem ();
  fetch_if mem_b ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem             (mem),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .exec_done       (exec_done),
    .branch          (branch),
    .branch_equality (branch_equality),
    .jump            (jump),
    .zero            (zero),
    .imm_ext         (imm_ext),
    .instret         (instret)
  );

  // Free-running instance: memory acks at once, execute commits at once
  assign mem_b.imem_ack   = mem_b.imem_req;
  assign mem_b.imem_rdata = 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .INSTRET_RESET(32'hFFFF_FFFF)) dut_b (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem             (mem_b),
    .instr           (instr_b),
    .instr_valid     (instr_valid_b),
    .pc              (pc_b),
    .pc_plus4        (pc_plus4_b),
    .exec_done       (instr_valid_b),
    .branch          (ctl_off),
    .branch_equality (ctl_off),
    .jump            (ctl_off),
    .zero            (ctl_off),
    .imm_ext         (imm_off),
    .instret         (instret_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: timed out waiting, expected DUT event", name);
  endtask

  // Monitor: a rising request or rising valid pops the next expectation
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_addr = 32'h0;

  always @(negedge clk) begin
    fetch_exp_t  e;
    logic [31:0] w;
    if (mem.imem_req === 1'b1 && prev_req !== 1'b1) begin
      if (fetch_q.size() == 0) begin
        reportTimeout("unexpected_fetch");
      end else begin
        e = fetch_q.pop_front();
        checkOutput({e.name, " imem_addr"}, mem.imem_addr, e.addr);
        checkOutput({e.name, " pc"}, pc, e.addr);
        checkOutput({e.name, " pc_plus4"}, pc_plus4, e.addr + 32'd4);
        checkOutput({e.name, " instret"}, instret, e.count);
      end
      held_addr = mem.imem_addr;
    end else if (mem.imem_req === 1'b1) begin
      checkOutput("addr_stable", mem.imem_addr, held_addr);
    end
    if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (instr_q.size() == 0) begin
        reportTimeout("unexpected_instr_valid");
      end else begin
        w = instr_q.pop_front();
        checkOutput("instr_latched", instr, w);
      end
    end
    prev_req   = mem.imem_req;
    prev_valid = instr_valid;
  end

  // One instruction: wait for the request, ack after ack_lat cycles, then commit
  task automatic applyStimulus(input int ack_lat, input logic [31:0] rdata,
                               input logic j, input logic b, input logic beq, input logic z,
                               input logic [31:0] imm, input logic [31:0] next_pc,
                               input string name, input bit stray);
    int n;
    n = 0;
    while (mem.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem.imem_req !== 1'b1) begin
      reportTimeout({name, " req"});
      return;
    end
    repeat (ack_lat) @(negedge clk);
    instr_q.push_back(rdata);
    mem.imem_ack   = 1'b1;
    mem.imem_rdata = rdata;
    @(negedge clk);
    mem.imem_ack   = 1'b0;
    mem.imem_rdata = ~rdata;
    checkOutput({name, " valid_latency"}, {31'b0, instr_valid}, 32'd1);
    if (stray) begin
      mem.imem_ack   = 1'b1;
      mem.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem.imem_ack = 1'b0;
      checkOutput({name, " stray_ack_instr"}, instr, rdata);
      checkOutput({name, " stray_ack_valid"}, {31'b0, instr_valid}, 32'd1);
    end
    jump            = j;
    branch          = b;
    branch_equality = beq;
    zero            = z;
    imm_ext         = imm;
    exec_done       = 1'b1;
    exp_instret     = exp_instret + 32'd1;
    fetch_q.push_back('{next_pc, exp_instret, name});
    @(negedge clk);
    exec_done       = 1'b0;
    jump            = 1'b0;
    branch          = 1'b0;
    branch_equality = 1'b0;
    zero            = 1'b0;
    imm_ext         = 32'h0;
  endtask

  initial begin
    int n;
    mem.imem_ack    = 1'b0;
    mem.imem_rdata  = 32'h0;
    exec_done       = 1'b0;
    jump            = 1'b0;
    branch          = 1'b0;
    branch_equality = 1'b0;
    zero            = 1'b0;
    imm_ext         = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset instr", instr, 32'h0);
    checkOutput("reset instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("reset imem_req", {31'b0, mem.imem_req}, 32'd0);
    checkOutput("reset instret", instret, 32'h0);

    exp_instret = 32'h0;
    fetch_q.push_back('{32'h0, 32'h0, "first_fetch"});
    reset_n = 1'b1;

    //            lat rdata          j     b     beq   z     imm            next pc
    applyStimulus(3, 32'h2008_0005, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_0010, "beq_to_10", 1'b0);
    applyStimulus(0, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0014, "seq_10", 1'b0);
    applyStimulus(1, 32'h1440_0002, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'h0000_0020, "bne_to_20", 1'b0);
    applyStimulus(0, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_001C, "beq_taken", 1'b0);
    applyStimulus(2, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0020, "seq_1c", 1'b0);
    applyStimulus(0, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0024, "beq_not_taken", 1'b0);
    applyStimulus(0, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0020, "beq_back_20", 1'b0);
    applyStimulus(0, 32'h1400_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_001C, "bne_taken", 1'b0);
    applyStimulus(0, 32'h1000_FFFC, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0FFF_FFFC, 32'h4000_0010, "far_branch", 1'b0);
    applyStimulus(1, {OP_J, 26'h0000100}, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0003, 32'h4000_0400, "jump_over_branch", 1'b0);
    applyStimulus(0, 32'h1000_FEFE, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2FFF_FEFE, 32'hFFFF_FFFC, "branch_to_top", 1'b0);
    applyStimulus(0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, "pc_wrap", 1'b1);

    // Reset while a fetch is outstanding, with an ack in the same cycle
    n = 0;
    while (mem.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem.imem_req !== 1'b1) reportTimeout("reset_in_fetch req");
    reset_n        = 1'b0;
    mem.imem_ack   = 1'b1;
    mem.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem.imem_ack = 1'b0;
    checkOutput("reset_in_fetch pc", pc, 32'h0);
    checkOutput("reset_in_fetch instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("reset_in_fetch instr", instr, 32'h0);
    checkOutput("reset_in_fetch imem_req", {31'b0, mem.imem_req}, 32'd0);
    checkOutput("reset_in_fetch instret", instret, 32'h0);
    exp_instret = 32'h0;
    fetch_q.push_back('{32'h0, 32'h0, "refetch"});
    reset_n = 1'b1;

    applyStimulus(1, 32'h2402_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, "post_reset_seq", 1'b0);

    n = 0;
    while (mem.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem.imem_req !== 1'b1) reportTimeout("final req");
    repeat (2) @(negedge clk);
    checkOutput("fetch_q drained", fetch_q.size(), 32'd0);
    checkOutput("instr_q drained", instr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Counter wrap on the instance whose counter starts at all ones
  initial begin
    int n;
    n = 0;
    while (reset_n !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (instr_valid_b !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (instr_valid_b !== 1'b1) begin
      reportTimeout("instret_wrap valid");
    end else begin
      checkOutput("instret_pre_wrap", instret_b, 32'hFFFF_FFFF);
      @(negedge clk);
      checkOutput("instret_wrap", instret_b, 32'h0000_0000);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
